onchip_ram_dp_avmm: RTL and testbench

//  Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2) and a

---
 rtl/onchip_ram_dp_avmm_if.sv | 24 ++
 rtl/onchip_ram_dp_avmm.sv | 82 ++++++++
 tb/tb_onchip_ram_dp_avmm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/onchip_ram_dp_avmm_if.sv
// onchip_ram_dp_avmm_if: Avalon-MM slave port bundle for one side of the dual-port RAM
interface onchip_ram_dp_avmm_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;
  logic                oob;
  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest, oob
  );
  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest, oob
  );
endinterface

// File: rtl/onchip_ram_dp_avmm.sv
// onchip_ram_dp_avmm: true dual-port byte-enabled RAM with two Avalon-MM slaves and 1-2 cycle read latency
module onchip_ram_dp_avmm #(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 15,
  parameter int    DEPTH        = 17740,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input logic                 clk,
  input logic                 reset_n,
  input logic                 clken,
  input logic                 reset_req,
  onchip_ram_dp_avmm_if.slave s1,
  onchip_ram_dp_avmm_if.slave s2
);
  localparam int              BE_W  = DATA_W / 8;
  localparam int              AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_en;
  logic [ADDR_W-1:0] w_addr [2];
  logic [BE_W-1:0]   w_be [2];
  logic [DATA_W-1:0] w_wdata [2];
  logic [DATA_W-1:0] w_rdata [2];
  logic              w_sel [2];
  logic              w_rreq [2];
  logic              w_wreq [2];
  logic              w_in [2];
  logic              w_acc [2];
  logic              w_rd [2];
  logic              w_wr [2];
  logic              w_vld [2];
  logic              w_oob [2];
  assign w_en    = clken & ~reset_req;
  assign w_addr  = '{s1.address, s2.address};
  assign w_be    = '{s1.byteenable, s2.byteenable};
  assign w_wdata = '{s1.writedata, s2.writedata};
  assign w_sel   = '{s1.chipselect, s2.chipselect};
  assign w_rreq  = '{s1.read, s2.read};
  assign w_wreq  = '{s1.write, s2.write};
  assign s1.waitrequest   = ~w_en;
  assign s2.waitrequest   = ~w_en;
  assign s1.readdata      = w_rdata[0];
  assign s2.readdata      = w_rdata[1];
  assign s1.readdatavalid = w_vld[0];
  assign s2.readdatavalid = w_vld[1];
  assign s1.oob           = w_oob[0];
  assign s2.oob           = w_oob[1];
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              r_vld [READ_LATENCY];
    logic [DATA_W-1:0] r_dat [READ_LATENCY];
    logic              r_oob;
    assign w_in[p]    = {1'b0, w_addr[p]} < LIMIT;
    assign w_acc[p]   = w_en & w_sel[p] & (w_rreq[p] | w_wreq[p]);
    assign w_rd[p]    = w_acc[p] & w_rreq[p] & ~w_wreq[p];
    assign w_wr[p]    = w_acc[p] & w_wreq[p] & w_in[p];
    assign w_vld[p]   = r_vld[READ_LATENCY-1];
    assign w_rdata[p] = r_dat[READ_LATENCY-1];
    assign w_oob[p]   = r_oob;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_vld <= '{default: 1'b0};
        r_dat <= '{default: '0};
        r_oob <= 1'b0;
      end else if (w_en) begin
        r_vld[0] <= w_rd[p];
        r_dat[0] <= (w_rd[p] && w_in[p]) ? r_mem[w_addr[p][AW-1:0]] : '0;
        r_oob    <= w_acc[p] & ~w_in[p];
        for (int k = 1; k < READ_LATENCY; k++) begin
          r_vld[k] <= r_vld[k-1];
          r_dat[k] <= r_dat[k-1];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (w_wr[1] && w_be[1][b]) r_mem[w_addr[1][AW-1:0]][8*b +: 8] <= w_wdata[1][8*b +: 8];
      if (w_wr[0] && w_be[0][b]) r_mem[w_addr[0][AW-1:0]][8*b +: 8] <= w_wdata[0][8*b +: 8];
    end
  end
endmodule

// File: tb/tb_onchip_ram_dp_avmm.sv
// tb_onchip_ram_dp_avmm: scoreboard bench driving identical traffic into a LAT=1 and a LAT=2 RAM
module tb_onchip_ram_dp_avmm;
  localparam int DEPTH = 17740;
  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b1;
  logic        reset_req = 1'b0;
  logic [14:0] addr [2];
  logic [3:0]  be [2];
  logic        cs [2];
  logic        rd [2];
  logic        wr [2];
  logic [31:0] wd [2];
  logic [31:0] rdat [4];
  logic        vld [4];
  logic        wreq [4];
  logic        oob [4];
  logic [31:0] mdl [int];
  exp_t        q [4][$];
  logic        exp_oob [2];
  int          ecnt = 0;
  int          n_chk = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  onchip_ram_dp_avmm_if #(.ADDR_W(15), .DATA_W(32)) ifs [4] ();
  // ifs[0..1] feed the LAT=1 instance, ifs[2..3] the LAT=2 instance, with the same stimulus
  for (genvar g = 0; g < 4; g++) begin : g_bus
    assign ifs[g].address    = addr[g % 2];
    assign ifs[g].byteenable = be[g % 2];
    assign ifs[g].chipselect = cs[g % 2];
    assign ifs[g].read       = rd[g % 2];
    assign ifs[g].write      = wr[g % 2];
    assign ifs[g].writedata  = wd[g % 2];
    assign rdat[g]           = ifs[g].readdata;
    assign vld[g]            = ifs[g].readdatavalid;
    assign wreq[g]           = ifs[g].waitrequest;
    assign oob[g]            = ifs[g].oob;
  end
  onchip_ram_dp_avmm #(.READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .s1(ifs[0]), .s2(ifs[1])
  );
  onchip_ram_dp_avmm #(.READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .s1(ifs[2]), .s2(ifs[3])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
      addr[p] = '0; be[p] = '0; wd[p] = '0;
    end
  endtask
  task automatic rd_op(input int p, input logic [14:0] a);
    cs[p] = 1'b1; rd[p] = 1'b1; wr[p] = 1'b0; addr[p] = a;
  endtask
  task automatic wr_op(input int p, input logic [14:0] a, input logic [31:0] d, input logic [3:0] b);
    cs[p] = 1'b1; rd[p] = 1'b0; wr[p] = 1'b1; addr[p] = a; wd[p] = d; be[p] = b;
  endtask
  // predict this edge from the model, advance the clock, then compare just after the edge
  task automatic tick();
    logic        en;
    logic [31:0] w;
    en = clken & ~reset_req;
    for (int p = 0; p < 2; p++) begin
      logic acc, inr;
      acc = en & cs[p] & (rd[p] | wr[p]);
      inr = int'(addr[p]) < DEPTH;
      exp_oob[p] = acc & ~inr;
      if (acc & rd[p] & ~wr[p]) begin
        w = inr ? mdl[int'(addr[p])] : 32'h0;
        q[p].push_back('{w, ecnt + 1});
        q[p + 2].push_back('{w, ecnt + 2});
      end
    end
    for (int p = 1; p >= 0; p--) begin
      if (en & cs[p] & wr[p] & (int'(addr[p]) < DEPTH)) begin
        w = mdl.exists(int'(addr[p])) ? mdl[int'(addr[p])] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[p][b]) w[8*b +: 8] = wd[p][8*b +: 8];
        mdl[int'(addr[p])] = w;
      end
    end
    @(posedge clk);
    #1;
    if (en) begin
      ecnt++;
      for (int k = 0; k < 4; k++) begin
        if (q[k].size() > 0 && q[k][0].due <= ecnt) begin
          chk($sformatf("valid_p%0d", k), 32'(vld[k]), 32'd1);
          chk($sformatf("data_p%0d", k), rdat[k], q[k][0].d);
          void'(q[k].pop_front());
        end else begin
          chk($sformatf("novalid_p%0d", k), 32'(vld[k]), 32'd0);
        end
        chk($sformatf("oob_p%0d", k), 32'(oob[k]), 32'(exp_oob[k % 2]));
        chk($sformatf("wait_p%0d", k), 32'(wreq[k]), 32'd0);
      end
    end else begin
      for (int k = 0; k < 4; k++) chk($sformatf("stallwait_p%0d", k), 32'(wreq[k]), 32'd1);
    end
  endtask
  task automatic check_reset_outputs();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid_p%0d", k), 32'(vld[k]), 32'd0);
      chk($sformatf("rst_data_p%0d", k), rdat[k], 32'd0);
      chk($sformatf("rst_oob_p%0d", k), 32'(oob[k]), 32'd0);
    end
  endtask
  initial begin
    idle();
    #12;
    check_reset_outputs();
    reset_n = 1'b1;
    // full write then read back
    wr_op(0, 15'h10, 32'hDEADBEEF, 4'hF); tick();
    idle(); rd_op(0, 15'h10); tick();
    idle(); tick(); tick();
    // partial write from s2 over the same word
    wr_op(1, 15'h10, 32'h11223344, 4'b0101); tick();
    idle(); rd_op(1, 15'h10); tick();
    idle(); tick(); tick();
    // same-address write collision, then cross-port read during write
    wr_op(0, 15'd5, 32'hAAAAAAAA, 4'b0011); wr_op(1, 15'd5, 32'h55555555, 4'b1111); tick();
    idle(); wr_op(0, 15'd5, 32'h12345678, 4'hF); rd_op(1, 15'd5); tick();
    idle(); rd_op(0, 15'd5); tick();
    idle(); tick(); tick();
    // read and write together on one port: write wins, no read returned
    wr_op(0, 15'd7, 32'hCAFEF00D, 4'hF); rd[0] = 1'b1; tick();
    idle(); rd_op(0, 15'd7); tick();
    idle(); tick(); tick();
    // read burst with a two-cycle stall (clken low, then reset_req high)
    wr_op(0, 15'd0, 32'h00000A00, 4'hF); wr_op(1, 15'd1, 32'h00000B11, 4'hF); tick();
    wr_op(0, 15'd2, 32'h00000C22, 4'hF); wr_op(1, 15'd3, 32'h00000D33, 4'hF); tick();
    idle(); rd_op(0, 15'd0); tick();
    rd_op(0, 15'd1); tick();
    rd_op(0, 15'd2); clken = 1'b0; tick();
    clken = 1'b1; reset_req = 1'b1; tick();
    reset_req = 1'b0; tick();
    rd_op(0, 15'd3); tick();
    idle(); tick(); tick();
    // out-of-range read and write, then confirm word 0 untouched
    rd_op(0, 15'(DEPTH)); wr_op(1, 15'(DEPTH), 32'hFFFFFFFF, 4'hF); tick();
    idle(); rd_op(0, 15'd0); rd_op(1, 15'(DEPTH - 1)); wr[1] = 1'b1; wd[1] = 32'h0BADCAFE; be[1] = 4'hF; tick();
    idle(); rd_op(1, 15'(DEPTH - 1)); tick();
    idle(); tick(); tick();
    // reset while a LAT=2 read is in flight: it must never surface
    rd_op(0, 15'h10); tick();
    idle();
    reset_n = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) q[k].delete();
    check_reset_outputs();
    reset_n = 1'b1;
    tick(); tick(); tick();
    rd_op(0, 15'h10); rd_op(1, 15'd2); tick();
    idle(); tick(); tick();
    for (int k = 0; k < 4; k++) chk($sformatf("drain_p%0d", k), 32'(q[k].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
